// File: rtl/cam_ram_lookup_if.sv
// Lookup, CAM-write and RAM-config signal bundle for cam_ram_lookup.
// master = key source / configuration agent, slave = the lookup engine.
interface cam_ram_lookup_if #(
  parameter int C_WIDTH  = 4,
  parameter int C_ADDR_W = 4,
  parameter int C_DATA_W = 32
);
  // No back-pressure anywhere: en, cam_we and ram_wr_en are single-cycle
  // strobes sampled on the rising clock edge. A cam_we seen while busy=1 is
  // dropped. lookup_valid marks the cycle in which lookup_data belongs to a
  // key that was sampled two edges earlier.
  logic                en;
  logic [C_WIDTH-1:0]  cmp_din;
  logic [C_WIDTH-1:0]  cmp_data_mask;
  logic                match;
  logic [C_ADDR_W-1:0] match_addr;
  logic [C_DATA_W-1:0] lookup_data;
  logic                lookup_valid;
  logic                cam_we;
  logic [C_ADDR_W-1:0] cam_wr_addr;
  logic [C_WIDTH-1:0]  cam_din;
  logic [C_WIDTH-1:0]  cam_data_mask;
  logic                cam_wr_valid;
  logic                busy;
  logic                ram_wr_en;
  logic [C_ADDR_W-1:0] ram_addr;
  logic [C_DATA_W-1:0] ram_data_in;
  logic [C_DATA_W-1:0] ram_data_out;

  modport master (
    output en, cmp_din, cmp_data_mask,
    output cam_we, cam_wr_addr, cam_din, cam_data_mask, cam_wr_valid,
    output ram_wr_en, ram_addr, ram_data_in,
    input  match, match_addr, lookup_data, lookup_valid, busy, ram_data_out
  );

  modport slave (
    input  en, cmp_din, cmp_data_mask,
    input  cam_we, cam_wr_addr, cam_din, cam_data_mask, cam_wr_valid,
    input  ram_wr_en, ram_addr, ram_data_in,
    output match, match_addr, lookup_data, lookup_valid, busy, ram_data_out
  );
endinterface

// File: rtl/cam_ram_lookup.sv
// Ternary CAM (priority-encoded) feeding a 2-stage action-RAM lookup pipeline.
// Optional macro CAM_MEM_INIT_EN marks all entries valid at reset and keeps RAM contents.
module cam_ram_lookup #(
  parameter int C_DEPTH  = 16,
  parameter int C_WIDTH  = 4,
  parameter int C_ADDR_W = 4,
  parameter int C_DATA_W = 32
`ifdef CAM_MEM_INIT_EN
  ,
  parameter string C_CAM_INIT_FILE = "cam_init.mem",
  parameter string C_RAM_INIT_FILE = "ram_init.mem"
`endif
) (
  input logic             clk,
  input logic             aresetn,
  cam_ram_lookup_if.slave io
);

  logic [C_WIDTH-1:0]  key_q  [C_DEPTH];
  logic [C_WIDTH-1:0]  mask_q [C_DEPTH];
  logic [C_DEPTH-1:0]  cam_valid;
  logic [C_DATA_W-1:0] ram_q  [C_DEPTH];

  logic [C_DEPTH-1:0]  hit;
  logic [C_ADDR_W-1:0] hit_addr;
  logic                busy_q;
  logic                wr_accept;

  logic                match_q;
  logic [C_ADDR_W-1:0] match_addr_q;
  logic                en_d;
  logic                lookup_valid_q;
  logic [C_DATA_W-1:0] lookup_data_q;
  logic [C_DATA_W-1:0] ram_dout_q;

  // A bit is compared only when neither the stored nor the lookup mask ignores it.
  always_comb begin
    hit = '0;
    for (int i = 0; i < C_DEPTH; i++) begin
      hit[i] = cam_valid[i] &&
               (((key_q[i] ^ io.cmp_din) & ~(mask_q[i] | io.cmp_data_mask)) == '0);
    end
  end

  // Scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    hit_addr = '0;
    for (int i = C_DEPTH - 1; i >= 0; i--) begin
      if (hit[i]) hit_addr = C_ADDR_W'(i);
    end
  end

  assign wr_accept = io.cam_we && !busy_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q <= 1'b0;
      for (int i = 0; i < C_DEPTH; i++) begin
`ifdef CAM_MEM_INIT_EN
        key_q[i]     <= '0;
        mask_q[i]    <= '0;
        cam_valid[i] <= 1'b1;
`else
        key_q[i]     <= '0;
        mask_q[i]    <= '0;
        cam_valid[i] <= 1'b0;
`endif
      end
    end else begin
      busy_q <= wr_accept;
      if (wr_accept) begin
        key_q[io.cam_wr_addr]     <= io.cam_din;
        mask_q[io.cam_wr_addr]    <= io.cam_data_mask;
        cam_valid[io.cam_wr_addr] <= io.cam_wr_valid;
      end
    end
  end

  // Config port: registered read-first, so a same-edge write returns the old word.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
`ifndef CAM_MEM_INIT_EN
      for (int i = 0; i < C_DEPTH; i++) ram_q[i] <= '0;
`endif
      ram_dout_q <= '0;
    end else begin
      ram_dout_q <= ram_q[io.ram_addr];
      if (io.ram_wr_en) ram_q[io.ram_addr] <= io.ram_data_in;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      match_q        <= 1'b0;
      match_addr_q   <= '0;
      en_d           <= 1'b0;
      lookup_valid_q <= 1'b0;
      lookup_data_q  <= '0;
    end else begin
      if (io.en) begin
        match_q      <= |hit;
        match_addr_q <= hit_addr;
      end
      en_d           <= io.en;
      lookup_valid_q <= en_d;
      lookup_data_q  <= match_q ? ram_q[match_addr_q] : '0;
    end
  end

  assign io.match        = match_q;
  assign io.match_addr   = match_addr_q;
  assign io.lookup_data  = lookup_data_q;
  assign io.lookup_valid = lookup_valid_q;
  assign io.busy         = busy_q;
  assign io.ram_data_out = ram_dout_q;

endmodule

// File: tb/tb_cam_ram_lookup.sv
// Bench for cam_ram_lookup: directed vector table, then random traffic,
// all cycles checked against a behavioural model of the lookup engine.
module tb_cam_ram_lookup;
  localparam int DEPTH = 16;
  localparam int KW    = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  cam_ram_lookup_if #(.C_WIDTH(KW), .C_ADDR_W(AW), .C_DATA_W(DW)) ifc ();

  cam_ram_lookup #(
    .C_DEPTH(DEPTH), .C_WIDTH(KW), .C_ADDR_W(AW), .C_DATA_W(DW)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .io(ifc)
  );

  typedef struct {
    logic          en;
    logic [KW-1:0] key;
    logic [KW-1:0] cmask;
    logic          cam_we;
    logic [AW-1:0] waddr;
    logic [KW-1:0] wkey;
    logic [KW-1:0] wmask;
    logic          wvalid;
    logic          ram_we;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          chk;
    logic          exp_match;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic [KW-1:0] m_key   [DEPTH];
  logic [KW-1:0] m_mask  [DEPTH];
  logic          m_valid [DEPTH];
  logic [DW-1:0] m_ram   [DEPTH];
  logic          m_match;
  logic [AW-1:0] m_addr;
  logic          m_busy;
  logic [DW:0]   exp_q[$];   // {lookup_valid, lookup_data} due at the next edge

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [KW-1:0] key, input logic [KW-1:0] cmask,
                     input logic cam_we, input logic [AW-1:0] waddr, input logic [KW-1:0] wkey,
                     input logic [KW-1:0] wmask, input logic wvalid,
                     input logic ram_we, input logic [AW-1:0] raddr, input logic [DW-1:0] rdata,
                     input logic chk, input logic exp_match, input logic [AW-1:0] exp_addr);
    vec_t v;
    v.en = en; v.key = key; v.cmask = cmask;
    v.cam_we = cam_we; v.waddr = waddr; v.wkey = wkey; v.wmask = wmask; v.wvalid = wvalid;
    v.ram_we = ram_we; v.raddr = raddr; v.rdata = rdata;
    v.chk = chk; v.exp_match = exp_match; v.exp_addr = exp_addr;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_key[i] = '0; m_mask[i] = '0; m_valid[i] = 1'b0; m_ram[i] = '0;
    end
    m_match = 1'b0;
    m_addr  = '0;
    m_busy  = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // Lowest valid entry whose non-ignored bits all equal the key.
  task automatic model_lookup(input logic [KW-1:0] key, input logic [KW-1:0] cm,
                              output logic hit, output logic [AW-1:0] addr);
    hit = 1'b0;
    addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && m_valid[i] && (((m_key[i] ^ key) & ~(m_mask[i] | cm)) == '0)) begin
        hit = 1'b1;
        addr = AW'(i);
      end
    end
  endtask

  task automatic drive_idle();
    ifc.en = 1'b0; ifc.cmp_din = '0; ifc.cmp_data_mask = '0;
    ifc.cam_we = 1'b0; ifc.cam_wr_addr = '0; ifc.cam_din = '0;
    ifc.cam_data_mask = '0; ifc.cam_wr_valid = 1'b0;
    ifc.ram_wr_en = 1'b0; ifc.ram_addr = '0; ifc.ram_data_in = '0;
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s match", tag),        DW'(ifc.match),        '0);
    check($sformatf("%s match_addr", tag),   DW'(ifc.match_addr),   '0);
    check($sformatf("%s lookup_data", tag),  ifc.lookup_data,       '0);
    check($sformatf("%s lookup_valid", tag), DW'(ifc.lookup_valid), '0);
    check($sformatf("%s busy", tag),         DW'(ifc.busy),         '0);
    check($sformatf("%s ram_data_out", tag), ifc.ram_data_out,      '0);
  endtask

  // Drives one cycle, advances the model across the edge, and checks every output.
  task automatic run_cycle(input vec_t v, input string tag);
    logic [DW-1:0] exp_rdo;
    logic [DW:0]   exp_s2;
    logic          acc;
    logic          h;
    logic [AW-1:0] a;
    ifc.en = v.en; ifc.cmp_din = v.key; ifc.cmp_data_mask = v.cmask;
    ifc.cam_we = v.cam_we; ifc.cam_wr_addr = v.waddr; ifc.cam_din = v.wkey;
    ifc.cam_data_mask = v.wmask; ifc.cam_wr_valid = v.wvalid;
    ifc.ram_wr_en = v.ram_we; ifc.ram_addr = v.raddr; ifc.ram_data_in = v.rdata;

    exp_rdo = m_ram[v.raddr];
    if (exp_q.size() == 0) begin
      exp_s2 = '0;
      errors++;
      $display("FAIL %s scoreboard queue empty", tag);
    end else begin
      exp_s2 = exp_q.pop_front();
    end
    if (v.en) begin
      model_lookup(v.key, v.cmask, h, a);
      m_match = h;
      m_addr  = a;
    end
    acc = v.cam_we && !m_busy;
    if (acc) begin
      m_key[v.waddr] = v.wkey; m_mask[v.waddr] = v.wmask; m_valid[v.waddr] = v.wvalid;
    end
    m_busy = acc;
    if (v.ram_we) m_ram[v.raddr] = v.rdata;
    exp_q.push_back({v.en, m_match ? m_ram[m_addr] : '0});

    @(posedge clk);
    #1;
    check($sformatf("%s match", tag),        DW'(ifc.match),        DW'(m_match));
    check($sformatf("%s match_addr", tag),   DW'(ifc.match_addr),   DW'(m_addr));
    check($sformatf("%s busy", tag),         DW'(ifc.busy),         DW'(m_busy));
    check($sformatf("%s ram_data_out", tag), ifc.ram_data_out,      exp_rdo);
    check($sformatf("%s lookup_valid", tag), DW'(ifc.lookup_valid), DW'(exp_s2[DW]));
    check($sformatf("%s lookup_data", tag),  ifc.lookup_data,       exp_s2[DW-1:0]);
    if (v.chk) begin
      check($sformatf("%s table match", tag),      DW'(ifc.match),      DW'(v.exp_match));
      check($sformatf("%s table match_addr", tag), DW'(ifc.match_addr), DW'(v.exp_addr));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    drive_idle();
    model_reset();
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;

    //  en key cm  we wa wk wm wv  rwe ra rd              chk em ea
    add(1, 4'h1, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 0, 0);
    add(0, 4'h0, 4'h0, 1, 0, 1, 0, 1,   1, 0, 32'hA0,       0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   1, 1, 32'hA1,       0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 1, 2, 0, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   1, 2, 32'hA2,       0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 2, 3, 0, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   1, 3, 32'hA3,       0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 3, 4, 0, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    add(1, 4'h1, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 0);
    add(1, 4'h2, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 1);
    add(1, 4'h3, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 2);
    add(1, 4'h4, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 3);
    add(0, 4'h0, 4'h0, 1, 5, 7, 0, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 9, 7, 0, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    add(1, 4'h7, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 5);
    add(0, 4'h0, 4'h0, 1, 5, 7, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    add(1, 4'h7, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 9);
    add(0, 4'h0, 4'h0, 1, 6, 8, 3, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    add(1, 4'hB, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 6);
    add(1, 4'h6, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 0, 0);
    add(1, 4'h3, 4'h0, 1, 2, 4'hC, 0, 1, 0, 0, 32'h0,       1, 1, 2);
    add(1, 4'h3, 4'h0, 1, 4, 4'hE, 0, 1, 0, 0, 32'h0,       1, 0, 0);
    add(1, 4'hE, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 0, 0);
    add(0, 4'h0, 4'h0, 1, 2, 3, 0, 1,   0, 0, 32'h0,        0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 0);
    add(1, 4'h3, 4'h0, 0, 0, 0, 0, 0,   0, 2, 32'h0,        1, 1, 2);
    add(1, 4'h3, 4'h0, 0, 0, 0, 0, 0,   1, 2, 32'hDEADBEEF, 1, 1, 2);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 2, 32'h0,        1, 1, 2);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 2, 32'h0,        0, 0, 0);
    add(1, 4'h0, 4'hF, 0, 0, 0, 0, 0,   0, 0, 32'h0,        1, 1, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 400; i++) begin
      v.en     = ($urandom_range(0, 3) != 0);
      v.key    = KW'($urandom_range(0, 15));
      v.cmask  = ($urandom_range(0, 4) == 0) ? KW'($urandom_range(0, 15)) : '0;
      v.cam_we = ($urandom_range(0, 2) == 0);
      v.waddr  = AW'($urandom_range(0, 15));
      v.wkey   = KW'($urandom_range(0, 15));
      v.wmask  = ($urandom_range(0, 3) == 0) ? KW'($urandom_range(0, 15)) : '0;
      v.wvalid = ($urandom_range(0, 4) != 0);
      v.ram_we = ($urandom_range(0, 2) == 0);
      v.raddr  = AW'($urandom_range(0, 15));
      v.rdata  = $urandom;
      v.chk    = 1'b0;
      v.exp_match = 1'b0;
      v.exp_addr  = '0;
      run_cycle(v, $sformatf("rnd%0d", i));
    end

    // Reset asserted during a CAM write cycle: the write must be lost.
    ifc.cam_we = 1'b1; ifc.cam_wr_addr = '0; ifc.cam_din = 4'hF;
    ifc.cam_data_mask = '0; ifc.cam_wr_valid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check_reset("midreset");
    @(posedge clk);
    #1;
    drive_idle();
    aresetn = 1'b1;
    model_reset();
    vecs.delete();
    add(1, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    add(1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    add(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i], $sformatf("post%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
